partial_sum_acc_ctrl: RTL and testbench

Sequencer for the bank of partial-sum BRAMs that sits behind the DSP cascade chains in the GeMM datapath. It accepts one partial-product beat per cycle across all lanes, performs a read-modify-write accumulation into the BRAMs over `cfg_passes` K-tiles, and streams the final sums out on the last pass. It owns BRAM port A (write) and port B (read, 3-cycle latency) for every lane; all lanes share one address sequence.

---
 rtl/partial_sum_acc_ctrl.sv | 178 +++++++++++++++++
 tb/tb_partial_sum_acc_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/partial_sum_acc_ctrl.sv
// Read-modify-write sequencer for the partial-sum BRAM bank behind the DSP cascades.
// Accumulates cfg_passes K-tiles per row and streams final sums on the last pass.
module partial_sum_acc_ctrl #(
   parameter int NUM_LANES  = 64,
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 9,
   parameter int RD_LAT     = 3,
   parameter int PASS_WIDTH = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [ADDR_WIDTH:0]              cfg_rows,
   input  logic [PASS_WIDTH-1:0]            cfg_passes,
   output logic                             busy,
   output logic                             done,
   output logic                             cfg_err,
   input  logic                             in_valid,
   input  logic [DATA_WIDTH*NUM_LANES-1:0]  in_data,
   output logic [NUM_LANES-1:0]             bram_ena,
   output logic [NUM_LANES-1:0]             bram_wea,
   output logic [ADDR_WIDTH*NUM_LANES-1:0]  bram_addra,
   output logic [DATA_WIDTH*NUM_LANES-1:0]  bram_dina,
   output logic [NUM_LANES-1:0]             bram_enb,
   output logic [ADDR_WIDTH*NUM_LANES-1:0]  bram_addrb,
   input  logic [DATA_WIDTH*NUM_LANES-1:0]  bram_doutb,
   output logic                             out_valid,
   output logic                             out_last,
   output logic [DATA_WIDTH*NUM_LANES-1:0]  out_data,
   output logic [1:0]                       state_dbg
);

   localparam int LANE_BITS = DATA_WIDTH * NUM_LANES;
   localparam logic [ADDR_WIDTH:0]   ROWS_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0]   ROWS_MIN = (ADDR_WIDTH+1)'(5);
   localparam logic [ADDR_WIDTH:0]   ROWS_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [PASS_WIDTH-1:0] PASS_ONE = PASS_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_WIDTH:0]    rows_q;
   logic [PASS_WIDTH-1:0]  passes_q;
   logic [PASS_WIDTH-1:0]  pass_q;
   logic [ADDR_WIDTH-1:0]  row_q;

   logic [RD_LAT-1:0]      dl_valid;
   logic [RD_LAT-1:0]      dl_first;
   logic [RD_LAT-1:0]      dl_last;
   logic [ADDR_WIDTH-1:0]  dl_row  [RD_LAT];
   logic [LANE_BITS-1:0]   dl_data [RD_LAT];

   logic                   wr_q;
   logic [ADDR_WIDTH-1:0]  out_row_q;
   logic [LANE_BITS-1:0]   sum_q;
   logic [LANE_BITS-1:0]   sum_next;

   logic cfg_ok, accept, is_first, is_last, row_end, pipe_empty;
   logic ex_valid, ex_last, ex_row_end;

   // Handshake: no backpressure anywhere; a beat is taken whenever in_valid is high in RUN,
   // and out_valid / bram_ena are single-cycle qualifiers the consumer must sample.
   assign cfg_ok   = (cfg_rows >= ROWS_MIN) && (cfg_rows <= ROWS_MAX) && (cfg_passes != '0);
   assign accept   = (state_q == RUN) && in_valid;
   assign is_first = (pass_q == '0);
   assign is_last  = (pass_q == passes_q - PASS_ONE);
   assign row_end  = ({1'b0, row_q} == rows_q - ROWS_ONE);

   assign ex_valid   = dl_valid[RD_LAT-1];
   assign ex_last    = dl_last[RD_LAT-1];
   assign ex_row_end = ({1'b0, dl_row[RD_LAT-1]} == rows_q - ROWS_ONE);
   assign pipe_empty = ~|dl_valid && !wr_q && !out_valid;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && cfg_ok) state_d = RUN;
         RUN:     if (accept && is_last && row_end) state_d = DRAIN;
         DRAIN:   if (pipe_empty) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rows_q   <= '0;
         passes_q <= '0;
         pass_q   <= '0;
         row_q    <= '0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_err <= (state_q == IDLE) && start && !cfg_ok;
         if (state_q == IDLE && start && cfg_ok) begin
            rows_q   <= cfg_rows;
            passes_q <= cfg_passes;
            pass_q   <= '0;
            row_q    <= '0;
         end else if (accept) begin
            if (row_end) begin
               row_q  <= '0;
               pass_q <= pass_q + PASS_ONE;
            end else begin
               row_q <= row_q + ADDR_WIDTH'(1);
            end
         end
      end
   end

   // The delay line advances every cycle so the exit stage lines up with the BRAM read data.
   always_ff @(posedge clk) begin
      if (rst) dl_valid <= '0;
      else     dl_valid <= {dl_valid[RD_LAT-2:0], accept};
   end

   always_ff @(posedge clk) begin
      dl_first   <= {dl_first[RD_LAT-2:0], is_first};
      dl_last    <= {dl_last[RD_LAT-2:0], is_last};
      dl_row[0]  <= row_q;
      dl_data[0] <= in_data;
      for (int i = 1; i < RD_LAT; i++) begin
         dl_row[i]  <= dl_row[i-1];
         dl_data[i] <= dl_data[i-1];
      end
   end

   always_comb begin
      sum_next = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (dl_first[RD_LAT-1])
            sum_next[k*DATA_WIDTH +: DATA_WIDTH] = dl_data[RD_LAT-1][k*DATA_WIDTH +: DATA_WIDTH];
         else
            sum_next[k*DATA_WIDTH +: DATA_WIDTH] = dl_data[RD_LAT-1][k*DATA_WIDTH +: DATA_WIDTH]
                                                 + bram_doutb[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // One register feeds both the write-back port and the result stream.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q      <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_row_q <= '0;
         sum_q     <= '0;
      end else begin
         wr_q      <= ex_valid && !ex_last;
         out_valid <= ex_valid && ex_last;
         out_last  <= ex_valid && ex_last && ex_row_end;
         if (ex_valid) begin
            out_row_q <= dl_row[RD_LAT-1];
            sum_q     <= sum_next;
         end
      end
   end

   assign bram_ena   = {NUM_LANES{wr_q}};
   assign bram_wea   = {NUM_LANES{wr_q}};
   assign bram_addra = {NUM_LANES{out_row_q}};
   assign bram_dina  = sum_q;
   assign out_data   = sum_q;
   assign bram_enb   = {NUM_LANES{accept && !is_first}};
   assign bram_addrb = {NUM_LANES{row_q}};

   assign done      = (state_q == DRAIN) && pipe_empty;
   assign busy      = (state_q == RUN) || ((state_q == DRAIN) && !pipe_empty);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_partial_sum_acc_ctrl.sv
// Bench for partial_sum_acc_ctrl: randomized beats, a BRAM model, and a row-accumulator
// reference whose expected sums are queued and checked by an independent output monitor.
module tb_partial_sum_acc_ctrl;

   localparam int NL = 64;
   localparam int DW = 64;
   localparam int AW = 9;
   localparam int RL = 3;
   localparam int PW = 16;
   localparam int LB = NL * DW;

   logic            clk, rst, start;
   logic [AW:0]     cfg_rows;
   logic [PW-1:0]   cfg_passes;
   logic            busy, done, cfg_err;
   logic            in_valid;
   logic [LB-1:0]   in_data;
   logic [NL-1:0]   bram_ena, bram_wea, bram_enb;
   logic [AW*NL-1:0] bram_addra, bram_addrb;
   logic [LB-1:0]   bram_dina, bram_doutb;
   logic            out_valid, out_last;
   logic [LB-1:0]   out_data;
   logic [1:0]      state_dbg;

   partial_sum_acc_ctrl #(
      .NUM_LANES(NL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(RL), .PASS_WIDTH(PW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_passes(cfg_passes),
      .busy(busy), .done(done), .cfg_err(cfg_err), .in_valid(in_valid), .in_data(in_data),
      .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
      .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb),
      .out_valid(out_valid), .out_last(out_last), .out_data(out_data), .state_dbg(state_dbg)
   );

   // clock / reset / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // BRAM model: port A write, port B read with fixed 3-cycle latency
   logic [LB-1:0] mem [512];
   logic [LB-1:0] rd_pipe [RL];
   always @(posedge clk) begin
      if (bram_ena[0] && bram_wea[0]) mem[bram_addra[AW-1:0]] <= bram_dina;
      if (bram_enb[0]) rd_pipe[0] <= mem[bram_addrb[AW-1:0]];
      rd_pipe[1] <= rd_pipe[0];
      rd_pipe[2] <= rd_pipe[1];
   end
   assign bram_doutb = rd_pipe[RL-1];

   // scoreboard state
   logic [LB:0]   exp_q[$];
   int            exp_cyc_q[$];
   logic [LB-1:0] acc [512];
   int n_checks = 0;
   int n_pass   = 0;
   int touch_cnt = 0;
   bit no_bram_mode = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [LB-1:0] lane_add(input logic [LB-1:0] a, input logic [LB-1:0] b);
      logic [LB-1:0] s;
      s = '0;
      for (int k = 0; k < NL; k++) s[k*DW +: DW] = a[k*DW +: DW] + b[k*DW +: DW];
      return s;
   endfunction

   function automatic logic [LB-1:0] make_beat(input int mode, input int r, input int p);
      logic [LB-1:0] b;
      b = '0;
      for (int k = 0; k < NL; k++) begin
         case (mode)
            0:       b[k*DW +: DW] = 64'(r + k);
            1:       b[k*DW +: DW] = {$urandom(), $urandom()};
            default: b[k*DW +: DW] = (p == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'd1;
         endcase
      end
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // output monitor
   initial begin
      logic [LB:0] e;
      int ec, bad;
      forever begin
         @(negedge clk);
         if (rst) continue;
         if (bram_enb[0] && bram_wea[0])
            chk("raw_same_addr", 64'(bram_addrb[AW-1:0] != bram_addra[AW-1:0]), 64'd1);
         if (no_bram_mode && (bram_enb[0] || bram_ena[0] || bram_wea[0])) touch_cnt++;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
               e  = exp_q.pop_front();
               ec = exp_cyc_q.pop_front();
               bad = 0;
               for (int k = 0; k < NL; k++)
                  if (out_data[k*DW +: DW] !== e[k*DW +: DW]) begin bad = k; break; end
               chk("out_data_lane", out_data[bad*DW +: DW], e[bad*DW +: DW]);
               chk("out_last", 64'(out_last), 64'(e[LB]));
               chk("out_latency", 64'(cyc), 64'(ec));
            end
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_bram_ena"}, 64'(|bram_ena | |bram_wea), 64'd0);
      chk({tag, "_bram_enb"}, 64'(|bram_enb), 64'd0);
      chk({tag, "_data_zero"}, 64'(|out_data | |bram_dina), 64'd0);
      chk({tag, "_state"}, 64'(state_dbg), 64'd0);
   endtask

   task automatic run_job(input int rows, input int passes, input int mode, input int gap_pct,
                          input bit no_bram, input bit poke, input bit abort);
      int last_cyc, got;
      logic [LB-1:0] beat;
      cfg_rows   = (AW+1)'(rows);
      cfg_passes = PW'(passes);
      start = 1'b1;
      tick();
      start = 1'b0;
      touch_cnt = 0;
      no_bram_mode = no_bram;
      last_cyc = 0;
      for (int p = 0; p < passes; p++) begin
         for (int r = 0; r < rows; r++) begin
            while ($urandom_range(99) < gap_pct) begin
               in_valid = 1'b0;
               tick();
            end
            beat = make_beat(mode, r, p);
            in_valid = 1'b1;
            in_data  = beat;
            last_cyc = cyc;
            acc[r] = (p == 0) ? beat : lane_add(acc[r], beat);
            if (p == passes - 1) begin
               exp_q.push_back({r == rows - 1, acc[r]});
               exp_cyc_q.push_back(cyc + 4);
            end
            if (abort && p == 1 && r == 3) begin
               rst = 1'b1;
               start = 1'b1;
               cfg_rows = (AW+1)'(6);
               cfg_passes = PW'(2);
               tick();
               rst = 1'b0;
               start = 1'b0;
               check_idle_outputs("mid_reset");
               in_valid = 1'b0;
               repeat (8) tick();
               chk("mid_reset_no_output", 64'(exp_q.size()), 64'd0);
               return;
            end
            if (poke && p == 0 && r == 2) begin
               start = 1'b1;
               cfg_rows = (AW+1)'(4);
            end
            tick();
            if (poke && p == 0 && r == 2) begin
               start = 1'b0;
               cfg_rows = (AW+1)'(rows);
               chk("start_while_busy_err", 64'(cfg_err), 64'd0);
               chk("start_while_busy_busy", 64'(busy), 64'd1);
            end
         end
      end
      in_valid = 1'b0;
      got = -1;
      for (int n = 0; n < 20; n++) begin
         if (done) begin got = cyc; break; end
         tick();
      end
      chk("done_cycle", 64'(got), 64'(last_cyc + 5));
      chk("busy_at_done", 64'(busy), 64'd0);
      tick();
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      if (no_bram) chk("bram_untouched", 64'(touch_cnt), 64'd0);
      no_bram_mode = 0;
      repeat (2) tick();
   endtask

   task automatic bad_cfg(input int rows, input int passes);
      cfg_rows   = (AW+1)'(rows);
      cfg_passes = PW'(passes);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
      chk("cfg_err_busy", 64'(busy), 64'd0);
      tick();
      chk("cfg_err_one_cycle", 64'(cfg_err), 64'd0);
      chk("cfg_err_stay_idle", 64'(busy), 64'd0);
   endtask

   // watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      cfg_rows = '0;
      cfg_passes = '0;
      repeat (3) tick();
      rst = 1'b0;
      check_idle_outputs("reset");

      run_job(8, 3, 0, 0, 1'b0, 1'b0, 1'b0);
      run_job(8, 3, 0, 50, 1'b0, 1'b0, 1'b0);
      run_job(5, 1, 1, 30, 1'b1, 1'b0, 1'b0);
      run_job(5, 2, 2, 0, 1'b0, 1'b0, 1'b0);
      bad_cfg(4, 3);
      bad_cfg(8, 0);
      bad_cfg(513, 1);
      run_job(6, 2, 1, 40, 1'b0, 1'b1, 1'b0);
      run_job(8, 3, 1, 20, 1'b0, 1'b0, 1'b1);
      run_job(6, 2, 1, 50, 1'b0, 1'b0, 1'b0);
      run_job(512, 2, 1, 0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
